// File: rtl/peripherals_param_if.sv
// -----------------------------------------------------------------------------
// peripherals_param_if
// Bundles the operator-panel signals of peripherals_param (push-button, byte
// switches, mode switch, operand bus, result input and 7-segment outputs).
//
// Parameters
//   DATA_W  : operand/result width in bits (multiple of 8)
//   NUM_OPS : number of operands exposed on the operand bus
//
// Modports
//   master : panel/system side; drives enter, inputdata, loaddata and dataR,
//            receives inputdata_ready, operands and disp3..disp0
//   slave  : peripherals_param side (mirror image of master)
// -----------------------------------------------------------------------------
interface peripherals_param_if #(
  parameter int DATA_W  = 32,
  parameter int NUM_OPS = 2
);
  logic                        enter;
  logic [7:0]                  inputdata;
  logic                        loaddata;
  logic                        inputdata_ready;
  logic [NUM_OPS*DATA_W-1:0]   operands;
  logic [DATA_W-1:0]           dataR;
  logic [6:0]                  disp3;
  logic [6:0]                  disp2;
  logic [6:0]                  disp1;
  logic [6:0]                  disp0;

  modport master (
    output enter, inputdata, loaddata, dataR,
    input  inputdata_ready, operands, disp3, disp2, disp1, disp0
  );

  modport slave (
    input  enter, inputdata, loaddata, dataR,
    output inputdata_ready, operands, disp3, disp2, disp1, disp0
  );
endinterface

// File: rtl/peripherals_param.sv
// -----------------------------------------------------------------------------
// peripherals_param
// Byte-at-a-time operand loader and result browser driven by a single
// push-button. Each button press writes one byte of the operands (load mode)
// or steps through the bytes of the result (browse mode); four 7-segment
// digits show what is being addressed.
//
// Parameters
//   DATA_W  : operand/result width, multiple of 8, 8..64
//   NUM_OPS : number of operands loaded, 1..3
//   DEB_CYC : debounce stability count (cycles), used only with the macro
//
// Ports
//   clk    : single clock, all state on the rising edge
//   reset  : asynchronous, active-high reset
//   bus    : peripherals_param_if.slave
//            enter           raw asynchronous push-button
//            inputdata[7:0]  byte to be written
//            loaddata        1 = load mode, 0 = browse mode (sampled on press)
//            inputdata_ready all operand bytes loaded
//            operands        operand k at [k*DATA_W +: DATA_W]
//            dataR           result to display
//            disp3..disp0    active-low segments {g,f,e,d,c,b,a}
//
// Configuration
//   PERIPH_DEBOUNCE_EN : when defined, the synchronised button must be high
//                        for DEB_CYC consecutive cycles before the press is
//                        accepted; otherwise the first synchronised rising
//                        edge is the press.
// -----------------------------------------------------------------------------
module peripherals_param #(
  parameter int DATA_W  = 32,
  parameter int NUM_OPS = 2,
  parameter int DEB_CYC = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  peripherals_param_if.slave   bus
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int OP_W  = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;

  localparam logic [6:0] GLYPH_R = 7'b0101111;

  // Reject unsupported configurations at elaboration time.
  if ((DATA_W % 8) != 0 || DATA_W < 8 || DATA_W > 64 ||
      NUM_OPS < 1 || NUM_OPS > 3 || DEB_CYC < 1) begin : g_bad_param
    $error("peripherals_param: unsupported parameter combination");
  end

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_READY,
    ST_SHOW
  } state_t;

  // ---------------------------------------------------------------------------
  // Button synchroniser and press detection
  // ---------------------------------------------------------------------------
  logic sync1_reg;
  logic sync2_reg;
  logic pulse;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= bus.enter;
      sync2_reg <= sync1_reg;
    end
  end

`ifdef PERIPH_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_CYC + 1);

  // deb_cnt_reg counts synchronised-high cycles seen so far in the current
  // press; the press is accepted on the DEB_CYC-th high sample. armed_reg
  // drops after acceptance so a held button cannot fire again until it has
  // been seen low.
  logic [DEB_W-1:0] deb_cnt_reg;
  logic             armed_reg;

  assign pulse = sync2_reg && armed_reg && (deb_cnt_reg == DEB_W'(DEB_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_cnt_reg <= '0;
      armed_reg   <= 1'b1;
    end else if (!sync2_reg) begin
      deb_cnt_reg <= '0;
      armed_reg   <= 1'b1;
    end else if (armed_reg) begin
      if (pulse) begin
        armed_reg <= 1'b0;
      end else begin
        deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
      end
    end
  end
`else
  logic sync_prev_reg;

  assign pulse = sync2_reg && !sync_prev_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_prev_reg <= 1'b0;
    end else begin
      sync_prev_reg <= sync2_reg;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Control FSM and counters
  // ---------------------------------------------------------------------------
  state_t           state_reg, state_next;
  logic [IDX_W-1:0] byte_idx_reg, byte_idx_next;
  logic [OP_W-1:0]  op_idx_reg, op_idx_next;
  logic [IDX_W-1:0] res_idx_reg, res_idx_next;
  logic             ready_reg, ready_next;
  logic             wr_en;

  logic [7:0] op_mem_reg [NUM_OPS][BYTES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_LOAD;
      byte_idx_reg <= '0;
      op_idx_reg   <= '0;
      res_idx_reg  <= '0;
      ready_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      byte_idx_reg <= byte_idx_next;
      op_idx_reg   <= op_idx_next;
      res_idx_reg  <= res_idx_next;
      ready_reg    <= ready_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    byte_idx_next = byte_idx_reg;
    op_idx_next   = op_idx_reg;
    res_idx_next  = res_idx_reg;
    ready_next    = ready_reg;
    wr_en         = 1'b0;

    if (pulse) begin
      unique case (state_reg)
        ST_LOAD: begin
          // A browse-mode press while loading is deliberately ignored.
          if (bus.loaddata) begin
            wr_en = 1'b1;
            if (byte_idx_reg == IDX_W'(BYTES - 1)) begin
              byte_idx_next = '0;
              if (op_idx_reg == OP_W'(NUM_OPS - 1)) begin
                op_idx_next = '0;
                state_next  = ST_READY;
                ready_next  = 1'b1;
              end else begin
                op_idx_next = op_idx_reg + OP_W'(1);
              end
            end else begin
              byte_idx_next = byte_idx_reg + IDX_W'(1);
            end
          end
        end

        ST_READY, ST_SHOW: begin
          if (bus.loaddata) begin
            // Restart: counters and ready clear, operand storage is kept.
            state_next    = ST_LOAD;
            byte_idx_next = '0;
            op_idx_next   = '0;
            res_idx_next  = '0;
            ready_next    = 1'b0;
          end else if (state_reg == ST_READY) begin
            state_next   = ST_SHOW;
            res_idx_next = '0;
          end else if (res_idx_reg == IDX_W'(BYTES - 1)) begin
            res_idx_next = '0;
          end else begin
            res_idx_next = res_idx_reg + IDX_W'(1);
          end
        end

        default: begin
          state_next = ST_LOAD;
        end
      endcase
    end
  end

  // Operand byte storage; must clear on reset, so it stays in flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_OPS; k++) begin
        for (int b = 0; b < BYTES; b++) begin
          op_mem_reg[k][b] <= 8'h00;
        end
      end
    end else if (wr_en) begin
      op_mem_reg[op_idx_reg][byte_idx_reg] <= bus.inputdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  genvar gi, gb;

  generate
    for (gi = 0; gi < NUM_OPS; gi++) begin : g_op
      for (gb = 0; gb < BYTES; gb++) begin : g_byte
        assign bus.operands[gi*DATA_W + gb*8 +: 8] = op_mem_reg[gi][gb];
      end
    end
  endgenerate

  logic [7:0] res_bytes [BYTES];

  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_res
      assign res_bytes[gi] = bus.dataR[gi*8 +: 8];
    end
  endgenerate

  assign bus.inputdata_ready = ready_reg;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] seg;
    unique case (v)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  logic [7:0] shown_byte;
  logic [6:0] disp3_c, disp2_c, disp1_c, disp0_c;

  always_comb begin
    shown_byte = 8'h00;
    disp3_c    = GLYPH_R;
    disp2_c    = hex7(4'(res_idx_reg));
    if (state_reg == ST_LOAD) begin
      shown_byte = op_mem_reg[op_idx_reg][byte_idx_reg];
      // The operand letters A, b, C share glyphs with hex digits A..C.
      disp3_c    = hex7(4'hA + 4'(op_idx_reg));
      disp2_c    = hex7(4'(byte_idx_reg));
    end else begin
      shown_byte = res_bytes[res_idx_reg];
    end
    disp1_c = hex7(shown_byte[7:4]);
    disp0_c = hex7(shown_byte[3:0]);
  end

  assign bus.disp3 = disp3_c;
  assign bus.disp2 = disp2_c;
  assign bus.disp1 = disp1_c;
  assign bus.disp0 = disp0_c;

endmodule

// File: doc/peripherals_param.md
PERIPHERALS_PARAM -- requirements
Module: peripherals_param

Interface
- REQ-001 Parameter: DATA_W, default 32, operand/result width in bits; multiple of 8, range 8..64; BYTES = DATA_W/8.
- REQ-002 Parameter: NUM_OPS, default 2, number of operands loaded; range 1..3.
- REQ-003 Parameter: DEB_CYC, default 16, debounce stability count in cycles; only used under REQ-031.
- REQ-004 Port: clk, input, 1, single clock; all state on rising edge.
- REQ-005 Port: reset, input, 1, asynchronous, active-high reset.
- REQ-006 Port: enter, input, 1, raw asynchronous push-button.
- REQ-007 Port: inputdata, input, 8, byte to be written.
- REQ-008 Port: loaddata, input, 1, 1 = load mode, 0 = result-browse mode; sampled on the pulse cycle.
- REQ-009 Port: inputdata_ready, output, 1, all operand bytes loaded.
- REQ-010 Port: operands, output, NUM_OPS*DATA_W, operand k at bits [k*DATA_W +: DATA_W].
- REQ-011 Port: dataR, input, DATA_W, result to display.
- REQ-012 Port: disp3, disp2, disp1, disp0, output, 7 each, active-low segments ordered {g,f,e,d,c,b,a}.

Function
- REQ-013 enter SHALL pass a 2-flop synchroniser; a one-cycle internal pulse fires on the synchronised rising edge; a held button yields one pulse.
- REQ-014 FSM states: LOAD, READY, SHOW.
- REQ-015 Counters: byte_idx (0..BYTES-1), op_idx (0..NUM_OPS-1), res_idx (0..BYTES-1).
- REQ-016 LOAD, pulse with loaddata=1: write inputdata to byte byte_idx of operand op_idx (byte 0 = LSB).
- REQ-017 LOAD, same pulse: increment byte_idx; at BYTES-1 wrap byte_idx to 0 and increment op_idx.
- REQ-018 LOAD, pulse on the last byte of the last operand: go to READY; inputdata_ready = 1 from the following cycle.
- REQ-019 LOAD, pulse with loaddata=0: ignored; no state, counter or data change.
- REQ-020 READY, pulse with loaddata=0: go to SHOW with res_idx = 0.
- REQ-021 SHOW, pulse with loaddata=0: res_idx increments; wraps BYTES-1 -> 0.
- REQ-022 READY or SHOW, pulse with loaddata=1 (restart): go to LOAD; byte_idx, op_idx, res_idx and inputdata_ready clear to 0.
- REQ-023 Restart SHALL NOT write or clear operands; bytes are replaced only as they are reloaded.
- REQ-024 Non-pulse cycles: all state holds; loaddata changes alone cause no transition.
- REQ-025 Displays are combinational from registered state and update the cycle after the pulse edge.
- REQ-026 LOAD display: disp3 = glyph A/b/C for op_idx 0/1/2; disp2 = hex byte_idx; disp1/disp0 = hi/lo nibble of the currently addressed operand byte.
- REQ-027 READY/SHOW display: disp3 = 'r' (7'b0101111); disp2 = hex res_idx; disp1/disp0 = hi/lo nibble of dataR byte res_idx.
- REQ-028 Hex glyphs are standard 0-F; 0 = 7'b1000000.

Reset
- REQ-029 On reset assertion, immediately and mid-operation: state LOAD; all counters 0; operands all 0; inputdata_ready 0; synchroniser and debounce state cleared.
- REQ-030 Outputs after reset: disp3 = 'A', disp2 = '0', disp1 = '0', disp0 = '0'; a pulse in the reset-release cycle is lost.

Configuration
- REQ-031 Macro PERIPH_DEBOUNCE_EN defined: the synchronised enter must stay high DEB_CYC consecutive cycles before the single pulse fires; any low sample restarts the count; re-arm only after a low.
- REQ-032 Macro PERIPH_DEBOUNCE_EN undefined: pulse fires on the first synchronised rising edge; DEB_CYC is unused.

Verification (DATA_W=32, NUM_OPS=2, macro undefined unless stated)
- REQ-033 Load: 8 pulses, loaddata=1, bytes 0x11..0x88 -> operands = {32'h88776655, 32'h44332211}; inputdata_ready rises the cycle after the 8th pulse.
- REQ-034 Browse: dataR=32'hDEADBEEF, pulse from READY with loaddata=0 -> disp1/disp0 show E,F; 4 more pulses show B,E / A,D / D,E / E,F (wrap), disp2 = 1,2,3,0.
- REQ-035 Ignore and hold: in LOAD, pulse with loaddata=0 -> no change; enter held 50 cycles -> exactly one byte written.
- REQ-036 Reset: assert reset after 3 loaded bytes -> operands = 0, byte_idx = 0, disp3 = 'A'.
- REQ-037 Restart: from SHOW, pulse with loaddata=1 -> inputdata_ready = 0, disp3 = 'A', old operand values still present until overwritten.
- REQ-038 Debounce, PERIPH_DEBOUNCE_EN defined, DEB_CYC=16: a 5-cycle high glitch -> no pulse; 20-cycle press -> exactly one pulse.
